// File: rtl/ram8_ctrl.sv
// ram8_ctrl: request/ready front end for an 8-word RAM behind a 3-to-8 decoder, with a clear sweep after reset
module ram8_ctrl #(
  parameter int DW = 8,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic          we,
  input  logic [2:0]    addr,
  input  logic [DW-1:0] wdata,
  input  logic          clr,
  output logic          ready,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic          init_done,
  output logic [2:0]    dec_a,
  output logic          dec_en,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  typedef enum logic [1:0] {RST, CLEAR, IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d, addr_q, addr_d;
  logic we_q, we_d, rvalid_q, rvalid_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  // register all state; reset drops every strobe immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RST;
      cnt_q    <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end
  // next state: sweep runs all 8 words, clr beats req in IDLE, ACCESS lasts one cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      RST: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
      CLEAR: begin
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd7) ? IDLE : CLEAR;
      end
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (req) begin
          state_d = ACCESS;
          addr_d  = addr;
          we_d    = we;
          wdata_d = wdata;
        end
      end
      ACCESS: begin
        state_d  = IDLE;
        rdata_d  = we_q ? rdata_q : mem_rdata;
        rvalid_d = !we_q;
      end
      default: state_d = RST;
    endcase
  end
  assign ready     = (state_q == IDLE);
  assign init_done = (state_q == IDLE) || (state_q == ACCESS);
  assign dec_en    = (state_q == CLEAR) || (state_q == ACCESS);
  assign mem_we    = (state_q == CLEAR) || ((state_q == ACCESS) && we_q);
  assign dec_a     = (state_q == CLEAR) ? cnt_q : addr_q;
  assign mem_wdata = (state_q == CLEAR) ? CLR_VAL : wdata_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
endmodule

// File: tb/tb_ram8_ctrl.sv
// tb_ram8_ctrl: randomized scoreboard bench for ram8_ctrl with an 8-word array model
module tb_ram8_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic req = 1'b0, we = 1'b0, clr = 1'b0;
  logic [2:0] addr = '0;
  logic [7:0] wdata = '0;
  logic ready, rvalid, init_done, dec_en, mem_we;
  logic [7:0] rdata, mem_wdata, mem_rdata;
  logic [2:0] dec_a;
  logic [7:0] mem0 [8];
  logic [7:0] ref0 [8];

  logic req1 = 1'b0, we1 = 1'b0, clr1 = 1'b0;
  logic [2:0] addr1 = '0;
  logic [15:0] wdata1 = '0;
  logic ready1, rvalid1, init_done1, dec_en1, mem_we1;
  logic [15:0] rdata1, mem_wdata1, mem_rdata1;
  logic [2:0] dec_a1;
  logic [15:0] mem1 [8];

  ram8_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .clr(clr),
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .init_done(init_done), .dec_a(dec_a),
    .dec_en(dec_en), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  ram8_ctrl #(.DW(16), .CLR_VAL(16'hFFFF)) dut16 (
    .clk(clk), .rst_n(rst_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1), .clr(clr1),
    .ready(ready1), .rvalid(rvalid1), .rdata(rdata1), .init_done(init_done1), .dec_a(dec_a1),
    .dec_en(dec_en1), .mem_we(mem_we1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  // array models: word selected by the decoder address, written at the edge while mem_we is high
  assign mem_rdata  = mem0[dec_a];
  assign mem_rdata1 = mem1[dec_a1];
  always @(posedge clk) if (mem_we) mem0[dec_a] <= mem_wdata;
  always @(posedge clk) if (mem_we1) mem1[dec_a1] <= mem_wdata1;

  int tests = 0, fails = 0;
  logic [7:0] q0 [$];
  logic [15:0] q1 [$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // monitor for the 8-bit instance: pops expected read data on every rvalid
  initial begin
    logic [7:0] exp_rd = '0;
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_rd = '0;
        prev = 1'b0;
      end else begin
        chk("we_implies_en", {63'b0, mem_we & ~dec_en}, 64'd0);
        if (rvalid) begin
          if (q0.size() == 0) chk("spurious_rvalid", 64'd1, 64'd0);
          else begin
            exp_rd = q0.pop_front();
            chk("rdata", {56'b0, rdata}, {56'b0, exp_rd});
          end
          chk("rvalid_width", {63'b0, prev}, 64'd0);
        end else chk("rdata_hold", {56'b0, rdata}, {56'b0, exp_rd});
        prev = rvalid;
      end
    end
  end

  // monitor for the 16-bit instance
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rvalid1) begin
        if (q1.size() == 0) chk("spurious_rvalid16", 64'd1, 64'd0);
        else chk("rdata16", {48'b0, rdata1}, {48'b0, q1.pop_front()});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {63'b0, ready}, 64'd1);
  endtask

  // issue one access at a negedge; returns at the negedge inside the ACCESS cycle
  task automatic access0(input logic w, input logic [2:0] a, input logic [7:0] d);
    wait_ready();
    req = 1'b1; we = w; addr = a; wdata = d;
    @(posedge clk);
    if (w) ref0[a] = d;
    else q0.push_back(ref0[a]);
    @(negedge clk);
    req = 1'b0;
    chk("acc_dec_a", {61'b0, dec_a}, {61'b0, a});
    chk("acc_dec_en", {63'b0, dec_en}, 64'd1);
    chk("acc_mem_we", {63'b0, mem_we}, {63'b0, w});
    chk("acc_ready", {63'b0, ready}, 64'd0);
    if (w) chk("acc_wdata", {56'b0, mem_wdata}, {56'b0, d});
  endtask

  task automatic chk_rst();
    chk("rst_ready", {63'b0, ready}, 64'd0);
    chk("rst_rvalid", {63'b0, rvalid}, 64'd0);
    chk("rst_rdata", {56'b0, rdata}, 64'd0);
    chk("rst_init_done", {63'b0, init_done}, 64'd0);
    chk("rst_dec_a", {61'b0, dec_a}, 64'd0);
    chk("rst_dec_en", {63'b0, dec_en}, 64'd0);
    chk("rst_mem_we", {63'b0, mem_we}, 64'd0);
    chk("rst_mem_wdata", {56'b0, mem_wdata}, 64'd0);
  endtask

  // full 8-word clear sweep starting at the edge after the current negedge
  task automatic sweep0();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("sw_dec_a", {61'b0, dec_a}, k);
      chk("sw_dec_en", {63'b0, dec_en}, 64'd1);
      chk("sw_mem_we", {63'b0, mem_we}, 64'd1);
      chk("sw_wdata", {56'b0, mem_wdata}, 64'd0);
      chk("sw_ready", {63'b0, ready}, 64'd0);
      chk("sw_init_done", {63'b0, init_done}, 64'd0);
    end
    @(negedge clk);
    chk("sw_end_ready", {63'b0, ready}, 64'd1);
    chk("sw_end_init", {63'b0, init_done}, 64'd1);
    for (int i = 0; i < 8; i++) ref0[i] = 8'h00;
  endtask

  task automatic read_all0();
    for (int i = 0; i < 8; i++) access0(1'b0, 3'(i), 8'h00);
  endtask

  initial begin
    logic [7:0] old;
    int n;
    // reset and initial sweep
    repeat (2) @(negedge clk);
    chk_rst();
    rst_n = 1'b1;
    sweep0();
    for (int i = 0; i < 8; i++) chk("array_cleared", {56'b0, mem0[i]}, 64'd0);
    for (int i = 0; i < 8; i++) chk("array16_cleared", {48'b0, mem1[i]}, 64'hFFFF);
    // write then read
    access0(1'b1, 3'd5, 8'hA5);
    access0(1'b0, 3'd5, 8'h00);
    // fill and back-to-back reads
    for (int i = 0; i < 8; i++) access0(1'b1, 3'(i), 8'(8'h10 + i));
    read_all0();
    // randomized traffic
    for (int i = 0; i < 60; i++)
      access0(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom));
    read_all0();
    // clr and req together: clear wins, the req is dropped
    @(negedge clk);
    wait_ready();
    clr = 1'b1; req = 1'b1; we = 1'b0; addr = 3'd3;
    @(posedge clk);
    #1 clr = 1'b0; req = 1'b0;
    sweep0();
    read_all0();
    // reset during a clear sweep at cnt=3
    for (int i = 0; i < 8; i++) access0(1'b1, 3'(i), 8'(8'h80 | i));
    @(negedge clk);
    wait_ready();
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_sw_dec_a", {61'b0, dec_a}, k);
    end
    #1 rst_n = 1'b0;
    #1 chk_rst();
    @(negedge clk);
    rst_n = 1'b1;
    sweep0();
    for (int i = 0; i < 8; i++) chk("array_recleared", {56'b0, mem0[i]}, 64'd0);
    // reset during a write access: the write is abandoned
    access0(1'b1, 3'd6, 8'h77);
    old = 8'h77;
    access0(1'b1, 3'd6, 8'h5A);
    #1 rst_n = 1'b0;
    #1 chk_rst();
    @(posedge clk);
    @(negedge clk);
    chk("write_abandoned", {56'b0, mem0[6]}, {56'b0, old});
    rst_n = 1'b1;
    sweep0();
    read_all0();
    // 16-bit instance with CLR_VAL=0xFFFF
    n = 0;
    while (!ready1 && n < 20) begin @(negedge clk); n++; end
    chk("ready16", {63'b0, ready1}, 64'd1);
    req1 = 1'b1; we1 = 1'b1; addr1 = 3'd2; wdata1 = 16'h1234;
    @(negedge clk);
    req1 = 1'b0;
    chk("acc16_we", {63'b0, mem_we1}, 64'd1);
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd2;
    @(posedge clk);
    q1.push_back(16'h1234);
    @(negedge clk);
    req1 = 1'b0;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd5;
    @(posedge clk);
    q1.push_back(16'hFFFF);
    @(negedge clk);
    req1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("queue0_drained", 64'(q0.size()), 64'd0);
    chk("queue1_drained", 64'(q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
